fv_core_if_issue: RTL and testbench

- Fetch-side producer for the EX-side instruction tracker.
- Buffers observed fetched instructions and issues up to MAX_ISSUE per cycle as a valid vector plus the PC of slot 1.
- Generates issue-side stall and kill indications.
- Accepts killed-instruction reports back from EX and replays the killed instruction ahead of buffered traffic.

---
 rtl/fv_if_pkg.sv | 20 ++
 rtl/fv_if_issue_fifo.sv | 64 ++++++
 rtl/fv_core_if_issue.sv | 167 ++++++++++++++++
 tb/tb_fv_core_if_issue.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fv_if_pkg.sv
// rtl/fv_if_pkg.sv - shared types and defaults for the fetch-side issue block.
// Optional replay support is controlled by macro FV_IF_REPLAY_EN.
package fv_if_pkg;

  localparam int INSTR_W_DEF = 32;
  localparam int ADDR_W_DEF  = 32;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pc;
  } if_issue_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPLAY = 2'd2,
    ST_FLUSH  = 2'd3
  } if_state_e;

endpackage

// File: rtl/fv_if_issue_fifo.sv
// rtl/fv_if_issue_fifo.sv - instruction FIFO with one push port and up to MAX_ISSUE pops per cycle.
// Head entries are presented combinationally on MAX_ISSUE read ports.
module fv_if_issue_fifo #(
  parameter int W         = 64,
  parameter int DEPTH     = 8,
  parameter int MAX_ISSUE = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_,
  input  logic                                 clear,
  input  logic                                 push,
  input  logic [W-1:0]                         push_data,
  input  logic [$clog2(MAX_ISSUE+1)-1:0]       npop,
  output logic [MAX_ISSUE-1:0][W-1:0]          head_data,
  output logic [$clog2(DEPTH):0]               count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(npop);
    count_d  = count_q + CW'(push) - CW'(npop);
    // Clear wins over any same-cycle push or pop.
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_comb begin
    for (int k = 0; k < MAX_ISSUE; k++) begin
      head_data[k] = mem_q[rd_ptr_q + AW'(k)];
    end
    count = count_q;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fv_core_if_issue.sv
// rtl/fv_core_if_issue.sv - fetch-side issue stage: buffers fetched instructions, multi-issues, flushes and replays.
// Replay buffer, REPLAY state and replay_drop exist only when FV_IF_REPLAY_EN is defined.
module fv_core_if_issue
  import fv_if_pkg::*;
#(
  parameter int INSTR_W   = INSTR_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DEPTH     = 8,
  parameter int MAX_ISSUE = 2
) (
  input  logic                               clk,
  input  logic                               reset_,
  input  logic                               enq_valid,
  output logic                               enq_ready,
  input  logic [INSTR_W-1:0]                 enq_instr,
  input  logic [ADDR_W-1:0]                  enq_pc,
  output logic [MAX_ISSUE-1:0][INSTR_W-1:0]  issue_instr,
  output logic [MAX_ISSUE-1:0]               issue_valid,
  output logic [ADDR_W-1:0]                  issue_pc,
  output logic                               issue_stall,
  output logic                               issue_kill,
  input  logic                               ex_stall,
  input  logic                               ex_kill,
  input  logic                               killed_found,
  input  logic [INSTR_W-1:0]                 killed_instr,
  input  logic [ADDR_W-1:0]                  killed_pc,
  output logic [$clog2(DEPTH):0]             occupancy,
  output logic                               replay_drop
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(MAX_ISSUE + 1);
  localparam int W  = INSTR_W + ADDR_W;

  if_state_e                   state_q, state_d;
  logic [MAX_ISSUE-1:0][W-1:0] head_data;
  logic [CW-1:0]               count;
  logic [CW-1:0]               count_next;
  logic [PW-1:0]               npop;
  logic [MAX_ISSUE-1:0]        run_valid;
  logic                        enq_fire;
  logic                        replay_pend;
  logic [INSTR_W-1:0]          replay_instr;
  logic [ADDR_W-1:0]           replay_pc;

  fv_if_issue_fifo #(
    .W         (W),
    .DEPTH     (DEPTH),
    .MAX_ISSUE (MAX_ISSUE)
  ) u_fifo (
    .clk       (clk),
    .reset_    (reset_),
    .clear     (ex_kill),
    .push      (enq_fire),
    .push_data ({enq_instr, enq_pc}),
    .npop      (npop),
    .head_data (head_data),
    .count     (count)
  );

`ifdef FV_IF_REPLAY_EN
  logic [INSTR_W-1:0] replay_instr_q, replay_instr_d;
  logic [ADDR_W-1:0]  replay_pc_q, replay_pc_d;
  logic               replay_drop_q, replay_drop_d;

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      replay_instr_q <= '0;
      replay_pc_q    <= '0;
      replay_drop_q  <= 1'b0;
    end else begin
      replay_instr_q <= replay_instr_d;
      replay_pc_q    <= replay_pc_d;
      replay_drop_q  <= replay_drop_d;
    end
  end

  assign replay_pend  = (state_q == ST_REPLAY);
  assign replay_instr = replay_instr_q;
  assign replay_pc    = replay_pc_q;
  assign replay_drop  = replay_drop_q;
`else
  logic unused_replay_in;

  assign unused_replay_in = ^{killed_found, killed_instr, killed_pc};
  assign replay_pend      = 1'b0;
  assign replay_instr     = '0;
  assign replay_pc        = '0;
  assign replay_drop      = 1'b0;
`endif

  always_comb begin
    enq_ready = (count < CW'(DEPTH)) && (state_q != ST_FLUSH);
    enq_fire  = enq_valid && enq_ready;

    for (int k = 0; k < MAX_ISSUE; k++) begin
      run_valid[k] = (count >= CW'(k + 1)) && !ex_stall && (state_q == ST_RUN);
    end
    npop = '0;
    for (int k = 0; k < MAX_ISSUE; k++) begin
      npop = npop + PW'(run_valid[k]);
    end
    count_next = count + CW'(enq_fire) - CW'(npop);

    // A pending replay owns slot 1 alone and never pops the FIFO.
    issue_valid = run_valid;
    if (replay_pend) begin
      issue_valid    = '0;
      issue_valid[0] = !ex_stall;
    end

    for (int k = 0; k < MAX_ISSUE; k++) begin
      issue_instr[k] = issue_valid[k] ? head_data[k][W-1:ADDR_W] : '0;
    end
    issue_pc = issue_valid[0] ? head_data[0][ADDR_W-1:0] : '0;
    if (replay_pend) begin
      issue_instr[0] = issue_valid[0] ? replay_instr : '0;
      issue_pc       = issue_valid[0] ? replay_pc : '0;
    end

    issue_stall = ((count != '0) || replay_pend) && ex_stall;
    issue_kill  = (state_q == ST_FLUSH);
    occupancy   = count;
  end

  always_comb begin
    state_d = state_q;
`ifdef FV_IF_REPLAY_EN
    replay_instr_d = replay_instr_q;
    replay_pc_d    = replay_pc_q;
    replay_drop_d  = replay_drop_q;
`endif
    case (state_q)
      ST_IDLE: if (enq_fire) state_d = ST_RUN;
      ST_RUN:  if (count_next == '0) state_d = ST_IDLE;
`ifdef FV_IF_REPLAY_EN
      ST_REPLAY: if (!ex_stall) state_d = (count_next != '0) ? ST_RUN : ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef FV_IF_REPLAY_EN
    // Only one replay can be held; a second report is lost and flagged.
    if (killed_found && !ex_kill) begin
      if (replay_pend) begin
        replay_drop_d = 1'b1;
      end else if (state_q != ST_FLUSH) begin
        state_d        = ST_REPLAY;
        replay_instr_d = killed_instr;
        replay_pc_d    = killed_pc;
      end
    end
`endif
    if (ex_kill) begin
      state_d = ST_FLUSH;
`ifdef FV_IF_REPLAY_EN
      replay_instr_d = '0;
      replay_pc_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_fv_core_if_issue.sv
// tb/tb_fv_core_if_issue.sv - directed self-checking bench for fv_core_if_issue.
// Replay scenarios are exercised when FV_IF_REPLAY_EN is defined; otherwise killed reports must be ignored.
module tb_fv_core_if_issue;

  logic             clk = 1'b0;
  logic             reset_;
  logic             enq_valid;
  logic             enq_ready;
  logic [31:0]      enq_instr;
  logic [31:0]      enq_pc;
  logic [1:0][31:0] issue_instr;
  logic [1:0]       issue_valid;
  logic [31:0]      issue_pc;
  logic             issue_stall;
  logic             issue_kill;
  logic             ex_stall;
  logic             ex_kill;
  logic             killed_found;
  logic [31:0]      killed_instr;
  logic [31:0]      killed_pc;
  logic [3:0]       occupancy;
  logic             replay_drop;

  int passed = 0;
  int total  = 0;

  fv_core_if_issue dut (
    .clk          (clk),
    .reset_       (reset_),
    .enq_valid    (enq_valid),
    .enq_ready    (enq_ready),
    .enq_instr    (enq_instr),
    .enq_pc       (enq_pc),
    .issue_instr  (issue_instr),
    .issue_valid  (issue_valid),
    .issue_pc     (issue_pc),
    .issue_stall  (issue_stall),
    .issue_kill   (issue_kill),
    .ex_stall     (ex_stall),
    .ex_kill      (ex_kill),
    .killed_found (killed_found),
    .killed_instr (killed_instr),
    .killed_pc    (killed_pc),
    .occupancy    (occupancy),
    .replay_drop  (replay_drop)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return 32'hA500_0000 | pc;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic v, input logic [31:0] pc);
    enq_valid = v;
    enq_pc    = pc;
    enq_instr = ins(pc);
  endtask

  task automatic quiet();
    enq(1'b0, 32'h0);
    ex_stall     = 1'b0;
    ex_kill      = 1'b0;
    killed_found = 1'b0;
    killed_instr = '0;
    killed_pc    = '0;
  endtask

  task automatic test_reset();
    reset_ = 1'b1;
    quiet();
    #12;
    total++; if (enq_ready !== 1'b1) $display("FAIL rst_enq_ready: got %b want 1", enq_ready); else passed++;
    total++; if (occupancy !== 4'd0) $display("FAIL rst_occupancy: got %0d want 0", occupancy); else passed++;
    total++; if ({issue_valid, issue_stall, issue_kill, replay_drop} !== 5'b0) $display("FAIL rst_flags: got %b want 00000", {issue_valid, issue_stall, issue_kill, replay_drop}); else passed++;
    total++; if (issue_pc !== 32'h0) $display("FAIL rst_issue_pc: got %h want 0", issue_pc); else passed++;
    @(posedge clk); #1;
    reset_ = 1'b0;
    cyc();
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) enq(1'b1, pcs[i]); else enq(1'b0, 32'h0);
      #1;
      if (i == 0) begin
        total++; if (issue_valid !== 2'b00) $display("FAIL stream_v0: got %b want 00", issue_valid); else passed++;
      end else begin
        total++; if (issue_valid !== 2'b01) $display("FAIL stream_v%0d: got %b want 01", i, issue_valid); else passed++;
        total++; if (issue_pc !== pcs[i-1]) $display("FAIL stream_pc%0d: got %h want %h", i, issue_pc, pcs[i-1]); else passed++;
        total++; if (issue_instr[0] !== ins(pcs[i-1])) $display("FAIL stream_instr%0d: got %h want %h", i, issue_instr[0], ins(pcs[i-1])); else passed++;
        total++; if (occupancy !== 4'd1) $display("FAIL stream_occ%0d: got %0d want 1", i, occupancy); else passed++;
      end
      cyc();
    end
    #1;
    total++; if (issue_valid !== 2'b00 || occupancy !== 4'd0) $display("FAIL stream_end: got v=%b occ=%0d want v=00 occ=0", issue_valid, occupancy); else passed++;
  endtask

  task automatic test_back_to_back();
    ex_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enq(1'b1, 32'h100 + 32'(4 * i));
      cyc();
    end
    enq(1'b0, 32'h0);
    #1;
    total++; if (issue_stall !== 1'b1) $display("FAIL b2b_stall: got %b want 1", issue_stall); else passed++;
    total++; if (issue_valid !== 2'b00 || occupancy !== 4'd4) $display("FAIL b2b_held: got v=%b occ=%0d want v=00 occ=4", issue_valid, occupancy); else passed++;
    ex_stall = 1'b0;
    #1;
    total++; if (issue_stall !== 1'b0) $display("FAIL b2b_stall_rel: got %b want 0", issue_stall); else passed++;
    total++; if (issue_valid !== 2'b11 || issue_pc !== 32'h100) $display("FAIL b2b_pair0: got v=%b pc=%h want v=11 pc=100", issue_valid, issue_pc); else passed++;
    total++; if (issue_instr[1] !== ins(32'h104)) $display("FAIL b2b_slot2: got %h want %h", issue_instr[1], ins(32'h104)); else passed++;
    cyc();
    total++; if (issue_valid !== 2'b11 || issue_pc !== 32'h108 || occupancy !== 4'd2) $display("FAIL b2b_pair1: got v=%b pc=%h occ=%0d want v=11 pc=108 occ=2", issue_valid, issue_pc, occupancy); else passed++;
    total++; if (issue_instr[1] !== ins(32'h10C)) $display("FAIL b2b_slot2b: got %h want %h", issue_instr[1], ins(32'h10C)); else passed++;
    cyc();
    total++; if (issue_valid !== 2'b00 || occupancy !== 4'd0) $display("FAIL b2b_end: got v=%b occ=%0d want v=00 occ=0", issue_valid, occupancy); else passed++;
  endtask

  task automatic test_full_wrap();
    ex_stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      enq(1'b1, 32'h400 + 32'(4 * i));
      cyc();
    end
    enq(1'b1, 32'h4F0);
    #1;
    total++; if (enq_ready !== 1'b0 || occupancy !== 4'd8) $display("FAIL full_ready: got rdy=%b occ=%0d want rdy=0 occ=8", enq_ready, occupancy); else passed++;
    cyc();
    enq(1'b0, 32'h0);
    ex_stall = 1'b0;
    #1;
    total++; if (occupancy !== 4'd8 || issue_valid !== 2'b11 || issue_pc !== 32'h400) $display("FAIL full_pop: got occ=%0d v=%b pc=%h want occ=8 v=11 pc=400", occupancy, issue_valid, issue_pc); else passed++;
    cyc();
    ex_stall = 1'b1;
    #1;
    total++; if (enq_ready !== 1'b1 || occupancy !== 4'd6) $display("FAIL full_reopen: got rdy=%b occ=%0d want rdy=1 occ=6", enq_ready, occupancy); else passed++;
    ex_stall = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      total++; if (issue_valid !== 2'b11 || issue_pc !== 32'h408 + 32'(8 * j)) $display("FAIL drain%0d: got v=%b pc=%h want v=11 pc=%h", j, issue_valid, issue_pc, 32'h408 + 32'(8 * j)); else passed++;
      cyc();
    end
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) enq(1'b1, 32'h500 + 32'(4 * i)); else enq(1'b0, 32'h0);
      #1;
      if (i > 0) begin
        total++; if (issue_valid !== 2'b01 || issue_pc !== 32'h500 + 32'(4 * (i - 1))) $display("FAIL wrap%0d: got v=%b pc=%h want v=01 pc=%h", i, issue_valid, issue_pc, 32'h500 + 32'(4 * (i - 1))); else passed++;
      end
      cyc();
    end
    #1;
    total++; if (issue_valid !== 2'b00 || occupancy !== 4'd0) $display("FAIL wrap_end: got v=%b occ=%0d want v=00 occ=0", issue_valid, occupancy); else passed++;
  endtask

  task automatic test_kill();
    ex_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      enq(1'b1, 32'h600 + 32'(4 * i));
      cyc();
    end
    enq(1'b1, 32'h6F0);
    ex_kill = 1'b1;
    cyc();
    quiet();
    #1;
    total++; if (issue_kill !== 1'b1) $display("FAIL kill_pulse: got %b want 1", issue_kill); else passed++;
    total++; if (occupancy !== 4'd0 || issue_valid !== 2'b00 || enq_ready !== 1'b0) $display("FAIL kill_state: got occ=%0d v=%b rdy=%b want occ=0 v=00 rdy=0", occupancy, issue_valid, enq_ready); else passed++;
    cyc();
    enq(1'b1, 32'h700);
    #1;
    total++; if (issue_kill !== 1'b0 || enq_ready !== 1'b1 || occupancy !== 4'd0) $display("FAIL kill_after: got kill=%b rdy=%b occ=%0d want kill=0 rdy=1 occ=0", issue_kill, enq_ready, occupancy); else passed++;
    cyc();
    enq(1'b0, 32'h0);
    #1;
    total++; if (issue_valid !== 2'b01 || issue_pc !== 32'h700) $display("FAIL kill_resume: got v=%b pc=%h want v=01 pc=700", issue_valid, issue_pc); else passed++;
    cyc();
  endtask

`ifdef FV_IF_REPLAY_EN
  task automatic test_replay();
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      enq(1'b1, 32'h100 + 32'(4 * i));
      cyc();
    end
    enq(1'b0, 32'h0);
    killed_found = 1'b1; killed_pc = 32'h200; killed_instr = ins(32'h200);
    cyc();
    killed_found = 1'b0;
    ex_stall = 1'b0;
    #1;
    total++; if (issue_valid !== 2'b01 || issue_pc !== 32'h200 || issue_instr[0] !== ins(32'h200)) $display("FAIL replay_slot: got v=%b pc=%h in=%h want v=01 pc=200 in=%h", issue_valid, issue_pc, issue_instr[0], ins(32'h200)); else passed++;
    total++; if (occupancy !== 4'd3) $display("FAIL replay_occ: got %0d want 3", occupancy); else passed++;
    cyc();
    total++; if (issue_valid !== 2'b11 || issue_pc !== 32'h100) $display("FAIL replay_resume0: got v=%b pc=%h want v=11 pc=100", issue_valid, issue_pc); else passed++;
    cyc();
    total++; if (issue_valid !== 2'b01 || issue_pc !== 32'h108) $display("FAIL replay_resume1: got v=%b pc=%h want v=01 pc=108", issue_valid, issue_pc); else passed++;
    cyc();
    ex_stall = 1'b1;
    enq(1'b1, 32'h110);
    cyc();
    enq(1'b0, 32'h0);
    killed_found = 1'b1; killed_pc = 32'h300; killed_instr = ins(32'h300);
    cyc();
    killed_pc = 32'h304; killed_instr = ins(32'h304);
    #1;
    total++; if (issue_stall !== 1'b1 || issue_valid !== 2'b00 || replay_drop !== 1'b0) $display("FAIL replay_held: got st=%b v=%b drop=%b want st=1 v=00 drop=0", issue_stall, issue_valid, replay_drop); else passed++;
    cyc();
    killed_found = 1'b0;
    ex_stall = 1'b0;
    #1;
    total++; if (replay_drop !== 1'b1) $display("FAIL replay_drop: got %b want 1", replay_drop); else passed++;
    total++; if (issue_valid !== 2'b01 || issue_pc !== 32'h300) $display("FAIL replay_first_kept: got v=%b pc=%h want v=01 pc=300", issue_valid, issue_pc); else passed++;
    cyc();
    total++; if (issue_valid !== 2'b01 || issue_pc !== 32'h110) $display("FAIL replay_after: got v=%b pc=%h want v=01 pc=110", issue_valid, issue_pc); else passed++;
    cyc();
    total++; if (replay_drop !== 1'b1 || issue_valid !== 2'b00) $display("FAIL replay_sticky: got drop=%b v=%b want drop=1 v=00", replay_drop, issue_valid); else passed++;
  endtask
`else
  task automatic test_replay();
    ex_stall = 1'b1;
    enq(1'b1, 32'h120);
    cyc();
    enq(1'b0, 32'h0);
    ex_stall = 1'b0;
    killed_found = 1'b1; killed_pc = 32'h200; killed_instr = ins(32'h200);
    #1;
    total++; if (issue_valid !== 2'b01 || issue_pc !== 32'h120) $display("FAIL noreplay_issue: got v=%b pc=%h want v=01 pc=120", issue_valid, issue_pc); else passed++;
    cyc();
    killed_found = 1'b0;
    #1;
    total++; if (issue_valid !== 2'b00 || replay_drop !== 1'b0) $display("FAIL noreplay_idle: got v=%b drop=%b want v=00 drop=0", issue_valid, replay_drop); else passed++;
  endtask
`endif

  task automatic test_reset_mid();
    ex_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enq(1'b1, 32'h800 + 32'(4 * i));
      cyc();
    end
    enq(1'b0, 32'h0);
    killed_found = 1'b1; killed_pc = 32'h2A0; killed_instr = ins(32'h2A0);
    cyc();
    killed_found = 1'b0;
    #1;
    total++; if (issue_stall !== 1'b1 || occupancy !== 4'd4) $display("FAIL mid_pre: got st=%b occ=%0d want st=1 occ=4", issue_stall, occupancy); else passed++;
    #1;
    reset_ = 1'b1;
    #1;
    total++; if (enq_ready !== 1'b1 || occupancy !== 4'd0) $display("FAIL mid_rst: got rdy=%b occ=%0d want rdy=1 occ=0", enq_ready, occupancy); else passed++;
    total++; if ({issue_valid, issue_stall, issue_kill, replay_drop} !== 5'b0 || issue_pc !== 32'h0 || issue_instr !== 64'h0) $display("FAIL mid_rst_outs: got flags=%b pc=%h want 0", {issue_valid, issue_stall, issue_kill, replay_drop}, issue_pc); else passed++;
    cyc();
    reset_ = 1'b0;
    ex_stall = 1'b0;
    enq(1'b1, 32'h900);
    cyc();
    enq(1'b0, 32'h0);
    #1;
    total++; if (issue_valid !== 2'b01 || issue_pc !== 32'h900) $display("FAIL mid_after: got v=%b pc=%h want v=01 pc=900", issue_valid, issue_pc); else passed++;
    cyc();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_full_wrap();
    test_kill();
    test_replay();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
